// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state
// encoding, HI/LO write-bus width and small arithmetic helpers.
package mdu_ctrl_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  localparam int EX_TO_HILO_W = 66;
  localparam int MDU_STEPS    = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  // Divide ops have op[1] set; signed ops have op[0] clear.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return (~v) + 64'd1;
  endfunction

endpackage

// File: rtl/mdu_datapath.sv
// Multiply/divide datapath: operand abs/latch, one shift-add or
// restoring-subtract step per cycle, and final sign fix of the result.
module mdu_datapath
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  // Multiply: r_opa = multiplicand (fixed), r_opb = multiplier (shifts right).
  // Divide:   r_opa = dividend (shifts left, MSB feeds the remainder),
  //           r_opb = divisor (fixed).
  logic        r_is_div;
  logic        r_sign_a;
  logic        r_sign_b;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [63:0] r_acc;

  logic        w_sign_a;
  logic        w_sign_b;
  logic [32:0] w_sum;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_sub;
  logic [63:0] w_acc_next;

  assign w_sign_a = op_is_signed(i_op) & i_src_a[31];
  assign w_sign_b = op_is_signed(i_op) & i_src_b[31];

  // Multiply step: add multiplicand into the upper half (33-bit carry kept),
  // then the whole accumulator moves right by one.
  assign w_sum = {1'b0, r_acc[63:32]} + (r_opb[0] ? {1'b0, r_opa} : 33'd0);

  // Divide step: shift the next dividend bit into the remainder; the shifted
  // remainder can reach 33 bits but the difference always fits in 32.
  assign w_rem_sh  = {r_acc[63:32], r_opa[31]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_opb});
  assign w_rem_sub = w_rem_sh[31:0] - r_opb;

  assign w_acc_next = r_is_div
    ? {(w_ge ? w_rem_sub : w_rem_sh[31:0]), r_acc[30:0], w_ge}
    : {w_sum, r_acc[31:1]};

  // Result sign fix: product negated on differing signs; quotient takes
  // sign_a^sign_b, remainder takes sign_a. Unsigned ops have both flags clear.
  always_comb begin
    o_hi = r_acc[63:32];
    o_lo = r_acc[31:0];
    if (r_is_div) begin
      if (r_sign_a)            o_hi = neg32(r_acc[63:32]);
      if (r_sign_a ^ r_sign_b) o_lo = neg32(r_acc[31:0]);
    end else if (r_sign_a ^ r_sign_b) begin
      {o_hi, o_lo} = neg64(r_acc);
    end
  end

  // Operand latch on accept, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_opa    <= 32'd0;
      r_opb    <= 32'd0;
      r_acc    <= 64'd0;
    end else if (i_load) begin
      r_is_div <= op_is_div(i_op);
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      r_opa    <= w_sign_a ? neg32(i_src_a) : i_src_a;
      r_opb    <= w_sign_b ? neg32(i_src_b) : i_src_b;
      r_acc    <= 64'd0;
    end else if (i_step) begin
      r_acc <= w_acc_next;
      if (r_is_div) r_opa <= {r_opa[30:0], 1'b0};
      else          r_opb <= {1'b0, r_opb[31:1]};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide controller: FSM, step counter, pipeline stall
// and flush handling, and the registered HI/LO write bus.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int STEPS = 32
)(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic [65:0] hilo_bus
);

  localparam int CNT_W = $clog2(STEPS);

  mdu_state_e       r_state;
  mdu_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [65:0]      r_hilo;
  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_hi;
  logic [31:0]      w_lo;

  assign w_last = (r_cnt == CNT_W'(STEPS - 1));
  assign busy   = (r_state != S_IDLE);

  // The write is held in r_hilo only through DONE; a same-cycle flush masks it.
  assign hilo_bus = (r_state == S_DONE && !flush) ? r_hilo : 66'd0;

  mdu_datapath u_dp (
    .clk     (clk),
    .resetn  (resetn),
    .i_load  (w_accept),
    .i_step  (r_state == S_CALC),
    .i_op    (op),
    .i_src_a (src_a),
    .i_src_b (src_b),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state, accept and stall; stall drops in DONE so EX retires there.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    stallreq = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !flush) begin
          w_accept = 1'b1;
          stallreq = 1'b1;
          w_next   = S_CALC;
        end
      end
      S_CALC: begin
        stallreq = 1'b1;
        if (flush)       w_next = S_IDLE;
        else if (w_last) w_next = S_FIX;
      end
      S_FIX: begin
        stallreq = 1'b1;
        w_next   = flush ? S_IDLE : S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Step counter: cleared on accept, advances once per CALC cycle.
  always_ff @(posedge clk) begin
    if (!resetn)                r_cnt <= '0;
    else if (w_accept)          r_cnt <= '0;
    else if (r_state == S_CALC) r_cnt <= r_cnt + 1'b1;
  end

  // Capture the sign-fixed result at the end of FIX; zero at all other times.
  always_ff @(posedge clk) begin
    if (!resetn || r_state != S_FIX || flush) r_hilo <= 66'd0;
    else                                      r_hilo <= {2'b11, w_hi, w_lo};
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stallreq;
  logic        busy;
  logic [65:0] hilo_bus;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.STEPS(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stallreq (stallreq),
    .busy     (busy),
    .hilo_bus (hilo_bus)
  );

  // Issue one op (cycle 0 = first negedge with start high), hold start until
  // the write is seen, then drop it and watch three more cycles.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int wcyc, output int stalls, output int writes,
                       output logic [65:0] bus);
    wcyc = -1; stalls = 0; writes = 0; bus = '0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (stallreq) stalls++;
      if (hilo_bus[65] || hilo_bus[64]) begin
        writes++;
        if (wcyc < 0) begin wcyc = c; bus = hilo_bus; end
      end
      @(negedge clk);
      if (wcyc >= 0) start = 1'b0;
      if (wcyc >= 0 && c >= wcyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", stallreq); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (hilo_bus !== 66'd0) begin n_bad++; $display("FAIL reset_bus got=%h exp=0", hilo_bus); end
    resetn = 1'b1;
  endtask

  task automatic test_mult();
    int w, s, n; logic [65:0] bus;
    do_op(MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003, w, s, n, bus);
    n_cmp++; if (w !== 34) begin n_bad++; $display("FAIL mult_write_cycle got=%0d exp=34", w); end
    n_cmp++; if (s !== 34) begin n_bad++; $display("FAIL mult_stall_cycles got=%0d exp=34", s); end
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL mult_write_count got=%0d exp=1", n); end
    n_cmp++; if (bus !== {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFA}) begin
      n_bad++; $display("FAIL mult_result got=%h exp=%h", bus, {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFA}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_idle_after got=%b exp=0", busy); end
  endtask

  task automatic test_multu();
    int w, s, n; logic [65:0] bus;
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w, s, n, bus);
    n_cmp++; if (w !== 34 || n !== 1) begin n_bad++; $display("FAIL multu_timing got=%0d/%0d exp=34/1", w, n); end
    n_cmp++; if (bus !== {2'b11, 32'hFFFF_FFFE, 32'h0000_0001}) begin
      n_bad++; $display("FAIL multu_result got=%h exp=%h", bus, {2'b11, 32'hFFFF_FFFE, 32'h0000_0001}); end
  endtask

  task automatic test_div();
    int w, s, n; logic [65:0] bus;
    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, w, s, n, bus);
    n_cmp++; if (w !== 34 || n !== 1) begin n_bad++; $display("FAIL div_timing got=%0d/%0d exp=34/1", w, n); end
    n_cmp++; if (bus !== {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      n_bad++; $display("FAIL div_neg7_by_2 got=%h exp=%h", bus, {2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
    do_op(MDU_DIVU, 32'd100, 32'd7, w, s, n, bus);
    n_cmp++; if (bus !== {2'b11, 32'd2, 32'd14}) begin
      n_bad++; $display("FAIL divu_100_by_7 got=%h exp=%h", bus, {2'b11, 32'd2, 32'd14}); end
  endtask

  task automatic test_div_boundary();
    int w, s, n; logic [65:0] bus;
    do_op(MDU_DIVU, 32'd5, 32'd0, w, s, n, bus);
    n_cmp++; if (w !== 34 || n !== 1) begin n_bad++; $display("FAIL divzero_timing got=%0d/%0d exp=34/1", w, n); end
    n_cmp++; if (bus !== {2'b11, 32'd5, 32'hFFFF_FFFF}) begin
      n_bad++; $display("FAIL divu_by_zero got=%h exp=%h", bus, {2'b11, 32'd5, 32'hFFFF_FFFF}); end
    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, w, s, n, bus);
    n_cmp++; if (bus !== {2'b11, 32'd0, 32'h8000_0000}) begin
      n_bad++; $display("FAIL div_overflow got=%h exp=%h", bus, {2'b11, 32'd0, 32'h8000_0000}); end
  endtask

  task automatic test_flush();
    int nw;
    @(negedge clk);
    start = 1'b1; op = MDU_MULT; src_a = 32'd1234; src_b = 32'd5678;
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b0;
    #1;
    n_cmp++; if (stallreq !== 1'b1) begin n_bad++; $display("FAIL flush_cycle10_stall got=%b exp=1", stallreq); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    n_cmp++; if (stallreq !== 1'b0) begin n_bad++; $display("FAIL flush_stall got=%b exp=0", stallreq); end
    nw = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (hilo_bus[65] || hilo_bus[64]) nw++;
    end
    n_cmp++; if (nw !== 0) begin n_bad++; $display("FAIL flush_no_write got=%0d exp=0", nw); end
  endtask

  task automatic test_flush_done();
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; src_a = 32'd100; src_b = 32'd7;
    repeat (34) @(negedge clk);
    flush = 1'b1;
    #1;
    n_cmp++; if (hilo_bus !== 66'd0) begin n_bad++; $display("FAIL flush_done_bus got=%h exp=0", hilo_bus); end
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_done_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int nw;
    @(negedge clk);
    start = 1'b1; op = MDU_DIV; src_a = 32'd1000; src_b = 32'd3;
    repeat (20) @(negedge clk);
    resetn = 1'b0; start = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++; if (stallreq !== 1'b0 || busy !== 1'b0 || hilo_bus !== 66'd0) begin
      n_bad++; $display("FAIL reset_mid got=%b/%b/%h exp=0/0/0", stallreq, busy, hilo_bus); end
    resetn = 1'b1;
    nw = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (hilo_bus[65] || hilo_bus[64]) nw++;
    end
    n_cmp++; if (nw !== 0) begin n_bad++; $display("FAIL reset_mid_no_write got=%0d exp=0", nw); end
  endtask

  task automatic test_back_to_back();
    int w1, w2, nw, st35; logic [65:0] b1, b2;
    w1 = -1; w2 = -1; nw = 0; st35 = -1; b1 = '0; b2 = '0;
    @(negedge clk);
    start = 1'b1; op = MDU_MULTU; src_a = 32'd6; src_b = 32'd7;
    for (int c = 0; c < 90; c++) begin
      #1;
      if (c == 35) st35 = int'(stallreq);
      if (hilo_bus[65] || hilo_bus[64]) begin
        nw++;
        if (w1 < 0) begin w1 = c; b1 = hilo_bus; end
        else if (w2 < 0) begin w2 = c; b2 = hilo_bus; end
      end
      @(negedge clk);
      if (w1 >= 0 && w2 < 0) begin op = MDU_DIVU; src_a = 32'd100; src_b = 32'd7; end
      if (w2 >= 0) start = 1'b0;
    end
    start = 1'b0;
    n_cmp++; if (w1 !== 34) begin n_bad++; $display("FAIL b2b_first_cycle got=%0d exp=34", w1); end
    n_cmp++; if (w2 !== 69) begin n_bad++; $display("FAIL b2b_second_cycle got=%0d exp=69", w2); end
    n_cmp++; if (nw !== 2) begin n_bad++; $display("FAIL b2b_write_count got=%0d exp=2", nw); end
    n_cmp++; if (st35 !== 1) begin n_bad++; $display("FAIL b2b_accept_stall got=%0d exp=1", st35); end
    n_cmp++; if (b1 !== {2'b11, 32'd0, 32'd42}) begin
      n_bad++; $display("FAIL b2b_first_result got=%h exp=%h", b1, {2'b11, 32'd0, 32'd42}); end
    n_cmp++; if (b2 !== {2'b11, 32'd2, 32'd14}) begin
      n_bad++; $display("FAIL b2b_second_result got=%h exp=%h", b2, {2'b11, 32'd2, 32'd14}); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_boundary();
    test_flush();
    test_flush_done();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide controller that owns every write into the HI/LO register pair. It sits beside the EX stage and accepts MULT, MULTU, DIV and DIVU. It runs a 32-step shift-add or restoring-subtract sequence, holding the pipeline with a stall request while it works. On completion it emits one HI/LO write in the `EX_TO_HILO` field order {hi_we, lo_we, hi, lo}, so HI/LO forwarding and writeback handle it like any other EX-stage write.

## Interface
Parameters:
- STEPS, 32, iteration count; equals operand width, not to be overridden.

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous, active-low reset
- start  in  1  EX holds a valid mul/div op (level; held while stalled)
- op  in  2  `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU` (defines.vh)
- src_a  in  32  multiplicand / dividend (rs)
- src_b  in  32  multiplier / divisor (rt)
- flush  in  1  exception/cancel; abort any operation in progress
- stallreq  out  1  hold IF/ID/EX
- busy  out  1  state ≠ IDLE
- hilo_bus  out  66  {hi_we, lo_we, hi_wdata, lo_wdata} → EX-to-HILO path

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE → CALC:
  - Condition: start && !flush.
  - Latch op, |src_a|, |src_b| and the sign flags. Signed ops only; unsigned latches raw values.
  - Clear the 64-bit accumulator and the step counter.
- CALC, one step per cycle:
  - Multiply: if multiplier LSB is set, add the multiplicand to the upper half; then shift the accumulator right by 1.
  - Divide: shift {rem, quo} left by 1; if rem ≥ divisor, subtract and set quo[0].
  - Counter runs 0..31. On step 31 go to FIX.
- FIX:
  - Signed multiply: negate the 64-bit product if signs differ.
  - Signed divide: the quotient takes sign_a^sign_b; the remainder takes sign_a.
  - Register the result, then go to DONE.
- DONE:
  - hi_we = lo_we = 1 for exactly this cycle.
  - MULT*: hi/lo carry product[63:32] / product[31:0].
  - DIV*: hi carries the remainder, lo carries the quotient.
  - Always go to IDLE next.
- start is ignored outside IDLE. Because EX advances during DONE, the held start from the same instruction is never re-accepted.
- Divide by zero: still runs the full sequence. Result: quo = 32'hFFFF_FFFF for DIVU, and the sign-fixed equivalent for DIV; rem = dividend. No exception is raised.
- DIV 0x8000_0000 / 0xFFFF_FFFF: quo = 0x8000_0000, rem = 0 (wrap, no trap).
- flush in any state: go to IDLE next cycle, no write issued. flush in DONE suppresses hi_we/lo_we that same cycle.
- resetn low: state IDLE, stallreq = 0, busy = 0, hilo_bus = 0, counter = 0, datapath registers = 0. Takes effect at the next edge and overrides flush and start.

## Timing
- stallreq is combinational: (IDLE && start && !flush) || CALC || FIX. It is low in DONE so EX retires in that cycle.
- Latency: start sampled at cycle 0; CALC cycles 1–32; FIX cycle 33; write at cycle 34. Total 34 stall cycles, with the write on the 35th.
- hilo_bus is registered and all-zero except during DONE.
- Back-to-back ops: the second start is accepted at the earliest in the cycle after DONE, i.e. 35 cycles after the first.
- Interaction with `hilo_reg`: the DONE-cycle write propagates through MEM/WB forwarding. A following MFHI/MFLO therefore sees the new value with no extra stall.

## Structure
- defines.vh owns:
  - `MDU_*` op codes
  - the state encoding (2-bit)
  - the `EX_TO_HILO` width (66)
- One sub-module, `mdu_datapath`:
  - 64-bit accumulator
  - 33-bit add/subtract
  - abs and negate logic
  - step logic, selected by op
- mdu_ctrl keeps the FSM, the counter, the stall and flush logic, and the output register.

## Test plan
- MULT 0xFFFF_FFFE (−2) × 0x0000_0003 → at cycle 34: hi = 0xFFFF_FFFF, lo = 0xFFFF_FFFA; stallreq high for cycles 0–33.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → hi = 0xFFFF_FFFE, lo = 0x0000_0001.
- DIV 0xFFFF_FFF9 (−7) / 2 → lo = 0xFFFF_FFFD (−3), hi = 0xFFFF_FFFF (−1); DIVU 100 / 7 → lo = 14, hi = 2.
- DIVU 5 / 0 → lo = 0xFFFF_FFFF, hi = 5; DIV 0x8000_0000 / 0xFFFF_FFFF → lo = 0x8000_0000, hi = 0.
- flush asserted at cycle 10 of a MULT → IDLE at cycle 11, no hi_we/lo_we ever, stallreq low from cycle 11. resetn low at cycle 20 of a DIV → all outputs 0 next cycle.
- start held through DONE with a second op queued → exactly one write per instruction; the second op starts the cycle after DONE.
